// File: rtl/hram_pkg.sv
// Shared constants, state encodings and CA decode helpers for the HyperBus target responder.
package hram_pkg;

  localparam int CA_BYTES   = 6;
  localparam int CA_RW      = 47;
  localparam int CA_AS      = 46;
  localparam int CA_LIN     = 45;

  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;
  localparam logic [31:0] CR0_ADDR    = 32'h0000_0800;
  localparam int          CR0_LAT2X   = 3;

  // hb_ck level after the edge that carries bits [15:8] of a word
  localparam logic BYTE_HI_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_RDATA,
    ST_WDATA,
    ST_REGW
  } hram_state_t;

  typedef enum logic [1:0] {
    REG_ID0,
    REG_ID1,
    REG_CR0,
    REG_NONE
  } hram_reg_t;

  function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
    return {ca[44:16], ca[2:0]};
  endfunction

  function automatic hram_reg_t reg_decode(input logic [31:0] a);
    if (a == 32'd0)    return REG_ID0;
    if (a == 32'd1)    return REG_ID1;
    if (a == CR0_ADDR) return REG_CR0;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/hram_target_responder_if.sv
// HyperBus pins between the converter (master) and the emulated device (slave).
interface hram_target_responder_if;
  logic       hb_cs_n;
  logic       hb_ck;
  logic       hb_reset_n;
  logic [7:0] hb_dq_in;
  logic [7:0] hb_dq_out;
  logic       hb_dq_oe;
  logic       hb_rwds_in;
  logic       hb_rwds_out;
  logic       hb_rwds_oe;

  modport master (
    output hb_cs_n, hb_ck, hb_reset_n, hb_dq_in, hb_rwds_in,
    input  hb_dq_out, hb_dq_oe, hb_rwds_out, hb_rwds_oe
  );

  modport slave (
    input  hb_cs_n, hb_ck, hb_reset_n, hb_dq_in, hb_rwds_in,
    output hb_dq_out, hb_dq_oe, hb_rwds_out, hb_rwds_oe
  );
endinterface

// File: rtl/hram_target_mem.sv
// 16-bit synchronous RAM with per-byte write enables and one clk of read latency.
module hram_target_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
    if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/hram_target_responder.sv
// HyperRAM device emulation: CA decode, initial latency, edge-aligned read data and
// RWDS-masked write capture, driven from a clk running at twice the bus clock.
module hram_target_responder
  import hram_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LAT_CYC    = 6,
  parameter int          WRAP_WORDS = 16,
  parameter logic [15:0] ID0_VALUE  = 16'h0C81,
  parameter logic [15:0] ID1_VALUE  = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  hram_target_responder_if.slave  hb,
  output logic                    protocol_err
);

  localparam int WB    = $clog2(WRAP_WORDS);
  localparam int LAT_W = $clog2(4*LAT_CYC+1);
  localparam logic [LAT_W-1:0] LAT_1X  = LAT_W'(2*LAT_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_2X  = LAT_W'(4*LAT_CYC - 1);
  localparam logic [2:0]       CA_LAST = 3'(CA_BYTES - 1);

  hram_state_t           state;
  hram_reg_t             reg_sel;
  logic                  ck_q, cs_q;
  logic [39:0]           ca_sr;
  logic [2:0]            ca_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_read, is_reg, is_lin;
  logic [15:0]           cr0;
  logic [7:0]            byte_hold;
  logic                  mask_hold, have_hi;
  logic [7:0]            dq_out;
  logic                  dq_oe, rwds_out, rwds_oe;

  logic                  edge_seen, hi_edge, cs_fall;
  logic [47:0]           ca_full;
  logic [31:0]           ca_addr;
  logic [LAT_W-1:0]      lat_last;
  logic [15:0]           mem_rdata, reg_word, rd_word, mem_wdata;
  logic                  mem_we;
  logic [1:0]            mem_be;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic lin);
    logic [ADDR_WIDTH-1:0] inc;
    inc = a + 1'b1;
    if (lin) return inc;
    return {a[ADDR_WIDTH-1:WB], inc[WB-1:0]};
  endfunction

  always_comb begin
    edge_seen = (hb.hb_ck != ck_q) && !hb.hb_cs_n;
    hi_edge   = (hb.hb_ck == BYTE_HI_LEVEL);
    cs_fall   = cs_q && !hb.hb_cs_n;
    ca_full   = {ca_sr, hb.hb_dq_in};
    ca_addr   = ca_word_addr(ca_full);
    lat_last  = cr0[CR0_LAT2X] ? LAT_2X : LAT_1X;
    case (reg_sel)
      REG_ID0: reg_word = ID0_VALUE;
      REG_ID1: reg_word = ID1_VALUE;
      REG_CR0: reg_word = cr0;
      default: reg_word = 16'h0000;
    endcase
    rd_word   = is_reg ? reg_word : mem_rdata;
    // Word commits on its second (low) byte; a lone high byte never reaches the RAM
    mem_we    = (state == ST_WDATA) && edge_seen && !hi_edge && have_hi && hb.hb_reset_n;
    mem_be    = {~mask_hold, ~hb.hb_rwds_in};
    mem_wdata = {byte_hold, hb.hb_dq_in};
  end

  hram_target_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (clk),
    .addr  (addr),
    .we    (mem_we),
    .be    (mem_be),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      reg_sel      <= REG_NONE;
      ck_q         <= 1'b0;
      cs_q         <= 1'b1;
      ca_sr        <= '0;
      ca_cnt       <= '0;
      lat_cnt      <= '0;
      addr         <= '0;
      is_read      <= 1'b0;
      is_reg       <= 1'b0;
      is_lin       <= 1'b0;
      cr0          <= CR0_DEFAULT;
      byte_hold    <= '0;
      mask_hold    <= 1'b0;
      have_hi      <= 1'b0;
      protocol_err <= 1'b0;
      dq_out       <= '0;
      dq_oe        <= 1'b0;
      rwds_out     <= 1'b0;
      rwds_oe      <= 1'b0;
    end else begin
      ck_q <= hb.hb_ck;
      cs_q <= hb.hb_cs_n;
      if (!hb.hb_reset_n) begin
        state        <= ST_IDLE;
        cr0          <= CR0_DEFAULT;
        protocol_err <= 1'b0;
        have_hi      <= 1'b0;
        dq_out       <= '0;
        dq_oe        <= 1'b0;
        rwds_out     <= 1'b0;
        rwds_oe      <= 1'b0;
      end else if (hb.hb_cs_n) begin
        if (state != ST_IDLE) begin
          if (state == ST_CA) protocol_err <= 1'b1;
          state    <= ST_IDLE;
          have_hi  <= 1'b0;
          dq_out   <= '0;
          dq_oe    <= 1'b0;
          rwds_out <= 1'b0;
          rwds_oe  <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: if (cs_fall) begin
            state    <= ST_CA;
            ca_cnt   <= '0;
            rwds_oe  <= 1'b1;
            rwds_out <= cr0[CR0_LAT2X];
          end
          ST_CA: if (edge_seen) begin
            ca_sr  <= ca_full[39:0];
            ca_cnt <= ca_cnt + 1'b1;
            if (ca_cnt == CA_LAST) begin
              rwds_oe  <= 1'b0;
              rwds_out <= 1'b0;
              is_read  <= ca_full[CA_RW];
              is_reg   <= ca_full[CA_AS];
              is_lin   <= ca_full[CA_LIN];
              addr     <= ca_addr[ADDR_WIDTH-1:0];
              reg_sel  <= reg_decode(ca_addr);
              lat_cnt  <= '0;
              have_hi  <= 1'b0;
              state    <= (!ca_full[CA_RW] && ca_full[CA_AS]) ? ST_REGW : ST_LAT;
            end
          end
          ST_LAT: if (edge_seen) begin
            if (lat_cnt == lat_last) state <= is_read ? ST_RDATA : ST_WDATA;
            else                     lat_cnt <= lat_cnt + 1'b1;
          end
          ST_RDATA: if (edge_seen) begin
            dq_oe    <= 1'b1;
            rwds_oe  <= 1'b1;
            rwds_out <= hb.hb_ck;
            // Advancing on the high byte gives the RAM a clk to fetch the next word
            if (hi_edge) begin
              dq_out    <= rd_word[15:8];
              byte_hold <= rd_word[7:0];
              addr      <= next_addr(addr, is_lin);
            end else begin
              dq_out    <= byte_hold;
            end
          end
          ST_WDATA: if (edge_seen) begin
            if (hi_edge) begin
              byte_hold <= hb.hb_dq_in;
              mask_hold <= hb.hb_rwds_in;
              have_hi   <= 1'b1;
            end else if (have_hi) begin
              have_hi   <= 1'b0;
              addr      <= next_addr(addr, is_lin);
            end
          end
          ST_REGW: if (edge_seen) begin
            if (hi_edge) begin
              byte_hold <= hb.hb_dq_in;
              have_hi   <= 1'b1;
            end else if (have_hi) begin
              have_hi <= 1'b0;
              if (reg_sel == REG_CR0) cr0 <= {byte_hold, hb.hb_dq_in};
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign hb.hb_dq_out   = dq_out;
  assign hb.hb_dq_oe    = dq_oe;
  assign hb.hb_rwds_out = rwds_out;
  assign hb.hb_rwds_oe  = rwds_oe;

endmodule

// File: tb/tb_hram_target_responder.sv
// Randomized bus-level bench for hram_target_responder against a word-array device model.
module tb_hram_target_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = 6;
  localparam int WRAP  = 16;

  logic clk = 1'b0;
  logic reset;
  logic protocol_err;

  hram_target_responder_if hb();

  hram_target_responder #(
    .ADDR_WIDTH (AW),
    .LAT_CYC    (LAT),
    .WRAP_WORDS (WRAP),
    .ID0_VALUE  (16'h0C81),
    .ID1_VALUE  (16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hb           (hb),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] mem_m [DEPTH];
  logic [15:0] cr0_m;
  logic [15:0] wq[$];
  logic [1:0]  mq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int a, input bit lin);
    if (lin) return (a + 1) % DEPTH;
    return (a / WRAP) * WRAP + ((a + 1) % WRAP);
  endfunction

  function automatic logic [15:0] reg_val(input int a);
    case (a)
      0:       return 16'h0C81;
      1:       return 16'h0000;
      'h800:   return cr0_m;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic bus_edge(input logic [7:0] d, input logic r);
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    @(negedge clk);
    hb.hb_ck      = ~hb.hb_ck;
    hb.hb_dq_in   = d;
    hb.hb_rwds_in = r;
    @(posedge clk); #1;
  endtask

  task automatic cs_start();
    @(negedge clk); hb.hb_ck = 1'b0;
    @(negedge clk); hb.hb_cs_n = 1'b0;
    @(posedge clk); #1;
    chk("ca_rwds", {hb.hb_rwds_oe, hb.hb_rwds_out, hb.hb_dq_oe}, {1'b1, cr0_m[3], 1'b0});
  endtask

  task automatic cs_end();
    @(negedge clk); hb.hb_cs_n = 1'b1;
    @(posedge clk); #1;
    chk("end_oe", {hb.hb_dq_oe, hb.hb_rwds_oe}, 2'b00);
  endtask

  task automatic send_ca(input bit rd, input bit as, input bit lin, input logic [31:0] a);
    logic [47:0] ca;
    logic [7:0]  b;
    ca = {rd, as, lin, a[31:3], 13'd0, a[2:0]};
    for (int i = 0; i < 6; i++) begin
      b = ca[47-8*i -: 8];
      bus_edge(b, 1'b0);
      if (i == 4) chk("ca_rwds_hold", hb.hb_rwds_oe, 1'b1);
    end
    chk("ca_release", {hb.hb_rwds_oe, hb.hb_dq_oe}, 2'b00);
  endtask

  task automatic latency();
    int n;
    n = cr0_m[3] ? 4*LAT : 2*LAT;
    for (int i = 0; i < n; i++) begin
      bus_edge(8'($urandom), 1'($urandom));
      chk("lat_quiet", {hb.hb_dq_oe, hb.hb_rwds_oe}, 2'b00);
    end
  endtask

  task automatic do_read(input bit lin, input bit as, input int addr, input int n);
    int a;
    logic [15:0] exp;
    cs_start();
    send_ca(1'b1, as, lin, 32'(addr));
    latency();
    a = addr % DEPTH;
    for (int w = 0; w < n; w++) begin
      exp = as ? reg_val(addr) : mem_m[a];
      bus_edge(8'($urandom), 1'b0);
      chk("rd_hi", {hb.hb_dq_oe, hb.hb_rwds_oe, hb.hb_rwds_out, hb.hb_dq_out},
          {1'b1, 1'b1, hb.hb_ck, exp[15:8]});
      bus_edge(8'($urandom), 1'b0);
      chk("rd_lo", {hb.hb_dq_oe, hb.hb_rwds_oe, hb.hb_rwds_out, hb.hb_dq_out},
          {1'b1, 1'b1, hb.hb_ck, exp[7:0]});
      a = nxt(a, lin);
    end
    cs_end();
  endtask

  task automatic do_write(input bit lin, input int addr, input bit extra);
    int a;
    cs_start();
    send_ca(1'b0, 1'b0, lin, 32'(addr));
    latency();
    a = addr % DEPTH;
    foreach (wq[i]) begin
      bus_edge(wq[i][15:8], mq[i][1]);
      bus_edge(wq[i][7:0], mq[i][0]);
      if (!mq[i][1]) mem_m[a][15:8] = wq[i][15:8];
      if (!mq[i][0]) mem_m[a][7:0]  = wq[i][7:0];
      if (i == 0) chk("wr_dq_oe", hb.hb_dq_oe, 1'b0);
      a = nxt(a, lin);
    end
    if (extra) bus_edge(8'hEE, 1'b0);
    cs_end();
  endtask

  task automatic reg_write(input int addr, input logic [15:0] v);
    cs_start();
    send_ca(1'b0, 1'b1, 1'b0, 32'(addr));
    bus_edge(v[15:8], 1'b0);
    bus_edge(v[7:0], 1'b0);
    cs_end();
    if (addr == 'h800) cr0_m = v;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int a, n;
    bit lin;
    hb.hb_cs_n    = 1'b1;
    hb.hb_ck      = 1'b0;
    hb.hb_reset_n = 1'b1;
    hb.hb_dq_in   = 8'h00;
    hb.hb_rwds_in = 1'b0;
    cr0_m         = 16'h8F1F;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {hb.hb_dq_oe, hb.hb_rwds_oe, hb.hb_rwds_out, hb.hb_dq_out, protocol_err}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_outs", {hb.hb_dq_oe, hb.hb_rwds_oe, hb.hb_rwds_out, hb.hb_dq_out, protocol_err}, 0);

    do_read(1'b1, 1'b1, 'h800, 1);
    do_read(1'b1, 1'b1, 0, 1);
    do_read(1'b1, 1'b1, 1, 1);
    do_read(1'b1, 1'b1, 5, 1);

    // fill every word so later reads have defined expectations
    wq.delete(); mq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      wq.push_back(16'($urandom)); mq.push_back(2'b00);
    end
    do_write(1'b1, 0, 1'b0);

    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444}; mq = '{2'b00, 2'b00, 2'b00, 2'b00};
    do_write(1'b1, 'h010, 1'b0);
    do_read(1'b1, 1'b0, 'h010, 4);

    wq = '{16'h1234}; mq = '{2'b00};
    do_write(1'b1, 'h020, 1'b0);
    wq = '{16'h00AA}; mq = '{2'b01};
    do_write(1'b1, 'h020, 1'b0);
    do_read(1'b1, 1'b0, 'h020, 1);

    do_read(1'b0, 1'b0, 'h01E, 20);
    do_read(1'b1, 1'b0, 'h3FE, 4);

    reg_write('h800, 16'h8F17);
    do_read(1'b1, 1'b0, 'h010, 4);
    reg_write('h123, 16'h0000);
    do_read(1'b1, 1'b1, 'h800, 1);

    // CS# released mid-CA, then bus reset restores cr0 and clears the error
    cs_start();
    bus_edge(8'hA0, 1'b0); bus_edge(8'h00, 1'b0); bus_edge(8'h00, 1'b0);
    cs_end();
    chk("perr_set", protocol_err, 1'b1);
    @(negedge clk); hb.hb_reset_n = 1'b0;
    @(posedge clk); #1;
    chk("perr_clr", protocol_err, 1'b0);
    @(negedge clk); hb.hb_reset_n = 1'b1;
    cr0_m = 16'h8F1F;
    do_read(1'b1, 1'b1, 'h800, 1);

    for (int t = 0; t < 40; t++) begin
      a   = $urandom_range(0, DEPTH-1) + $urandom_range(0, 3) * DEPTH;
      n   = $urandom_range(1, 20);
      lin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_read(lin, 1'b0, a, n);
        4, 5, 6: begin
          wq.delete(); mq.delete();
          for (int i = 0; i < n; i++) begin
            wq.push_back(16'($urandom));
            mq.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
          end
          do_write(lin, a, $urandom_range(0, 3) == 0);
        end
        7, 8: begin
          case ($urandom_range(0, 3))
            0:       do_read(1'b1, 1'b1, 0, 1);
            1:       do_read(1'b1, 1'b1, 1, 1);
            2:       do_read(1'b1, 1'b1, 'h800, 1);
            default: do_read(1'b1, 1'b1, $urandom_range(2, 'h7FF), 1);
          endcase
        end
        default: reg_write(($urandom_range(0, 3) == 0) ? 'h801 : 'h800,
                           ($urandom_range(0, 1) == 0) ? 16'h8F17 : 16'h8F1F);
      endcase
    end
    chk("perr_idle", protocol_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
